// File: rtl/subber_ahead_seq.sv
// Multi-cycle subtractor: a - b - bin over WIDTH bits, CHUNK bits per cycle,
// with a borrow-lookahead slice per chunk and valid/ready on both sides.
module subber_ahead_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic [1:0]       dbg_state_o
);
    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;
    logic             r_zero;

    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;
    logic [CHUNK-1:0] w_g;
    logic [CHUNK-1:0] w_p;
    logic [CHUNK:0]   w_c;
    logic [CHUNK-1:0] w_d;
    logic [WIDTH-1:0] w_diff_next;

    // Each c[j+1] is a flat sum of products of g/p terms and the incoming
    // borrow, so no borrow ripples bit-to-bit through the chunk.
    always_comb begin
        logic v_acc;
        logic v_prop;
        w_a         = r_a[int'(r_cnt) * CHUNK +: CHUNK];
        w_b         = r_b[int'(r_cnt) * CHUNK +: CHUNK];
        w_g         = ~w_a & w_b;
        w_p         = ~w_a | w_b;
        w_c         = '0;
        w_c[0]      = r_borrow;
        v_acc       = 1'b0;
        v_prop      = 1'b1;
        for (int j = 0; j < CHUNK; j++) begin
            v_acc  = 1'b0;
            v_prop = 1'b1;
            for (int i = j; i >= 0; i--) begin
                v_acc  = v_acc | (w_g[i] & v_prop);
                v_prop = v_prop & w_p[i];
            end
            w_c[j+1] = v_acc | (v_prop & r_borrow);
        end
        w_d         = w_a ^ w_b ^ w_c[CHUNK-1:0];
        w_diff_next = r_diff;
        w_diff_next[int'(r_cnt) * CHUNK +: CHUNK] = w_d;
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid never waits on ready, and in_ready/out_valid come
    // straight from flops so neither depends combinationally on the other side.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_borrow    <= 1'b0;
            r_cnt       <= '0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        r_a        <= a_i;
                        r_b        <= b_i;
                        r_borrow   <= bin_i;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_diff   <= w_diff_next;
                    r_borrow <= w_c[CHUNK];
                    if (r_cnt == LAST) begin
                        r_bout      <= w_c[CHUNK];
                        r_ovf       <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) &
                                       (r_a[WIDTH-1] ^ w_diff_next[WIDTH-1]);
                        r_zero      <= (w_diff_next == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_out_valid;
    assign diff_o      = r_diff;
    assign bout_o      = r_bout;
    assign ovf_o       = r_ovf;
    assign zero_o      = r_zero;
    assign dbg_state_o = r_state;
endmodule

// File: tb/tb_subber_ahead_seq.sv
// Bench for subber_ahead_seq: directed corner cases, backpressure, mid-run
// reset and a randomized regression against an arithmetic reference model.
module tb_subber_ahead_seq;
    parameter int WIDTH = 16;
    parameter int CHUNK = 4;
    localparam int N  = WIDTH / CHUNK;
    localparam int EW = WIDTH + 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             bin_in = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;
    logic [1:0]       dbg_state;

    subber_ahead_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a_in),
        .b_i         (b_in),
        .bin_i       (bin_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .diff_o      (diff),
        .bout_o      (bout),
        .ovf_o       (ovf),
        .zero_o      (zero),
        .dbg_state_o (dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];
    int            acc_q[$];
    int            ready_mode = 1;
    bit            holding = 1'b0;
    logic [EW-1:0] held = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic bin);
        longint ua, ub, sa, sb, full, sres, smax, smin;
        logic [63:0]      fbits;
        logic [WIDTH-1:0] d;
        logic             bo, ov;
        ua    = longint'(a);
        ub    = longint'(b);
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        full  = ua - ub - longint'(bin);
        fbits = full;
        d     = fbits[WIDTH-1:0];
        bo    = (ua < ub + longint'(bin));
        sres  = sa - sb - longint'(bin);
        smax  = (longint'(1) <<< (WIDTH - 1)) - 1;
        smin  = -smax - 1;
        ov    = (sres > smax) || (sres < smin);
        return {d, bo, ov, (d == '0)};
    endfunction

    // scoreboard monitor: pops on the first cycle of each result, then checks hold
    always @(negedge clk) begin
        logic [EW-1:0] e;
        int            t;
        if (rst) begin
            holding = 1'b0;
        end else if (out_valid) begin
            if (!holding) begin
                if (exp_q.size() == 0) begin
                    check("out_valid_without_pending", out_valid, 1'b0);
                    held = {diff, bout, ovf, zero};
                end else begin
                    e = exp_q.pop_front();
                    t = acc_q.pop_front();
                    check("diff", diff, e[EW-1:3]);
                    check("bout", bout, e[2]);
                    check("ovf", ovf, e[1]);
                    check("zero", zero, e[0]);
                    check("latency", cyc - t, N);
                    held = e;
                end
                holding = 1'b1;
            end else begin
                check("hold_stable", {diff, bout, ovf, zero}, held);
                check("in_ready_in_done", in_ready, 1'b0);
            end
        end
        case (ready_mode)
            0:       out_ready = ($urandom_range(0, 99) < 65);
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
        if (!rst && out_valid && out_ready) holding = 1'b0;
    end

    // driver: waits for in_ready (garbage on the inputs meanwhile), then issues one op
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
        int budget;
        budget = 0;
        @(negedge clk);
        while (!in_ready) begin
            in_valid = 1'($urandom_range(0, 1));
            a_in     = WIDTH'($urandom);
            b_in     = WIDTH'($urandom);
            bin_in   = 1'($urandom_range(0, 1));
            budget++;
            if (budget > 500) begin
                check("in_ready_timeout", in_ready, 1'b1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        a_in     = a;
        b_in     = b;
        bin_in   = bin;
        in_valid = 1'b1;
        exp_q.push_back(model(a, b, bin));
        acc_q.push_back(cyc + 1);
        @(negedge clk);
        in_valid = 1'b0;
        a_in     = WIDTH'($urandom);
        b_in     = WIDTH'($urandom);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 || out_valid || holding) begin
            budget++;
            if (budget > 2000) begin
                check("drain_timeout", exp_q.size(), 0);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_valid();
        int budget;
        budget = 0;
        while (!out_valid) begin
            budget++;
            if (budget > 500) begin
                check("out_valid_timeout", out_valid, 1'b1);
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=%0d cycles required=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [EW-1:0]    bp_exp;
        logic [WIDTH-1:0] ra, rb;
        int               rst_edge;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_zero", zero, 1'b1);
        check("rst_state", dbg_state, 2'd0);
        rst = 1'b0;

        // directed corners
        ready_mode = 1;
        send(WIDTH'(16'h0005), WIDTH'(16'h0003), 1'b0); drain();
        send(WIDTH'(16'h0003), WIDTH'(16'h0005), 1'b0); drain();
        send(WIDTH'(16'h1000), WIDTH'(16'h0FFF), 1'b1); drain();
        send(WIDTH'(16'h8000), WIDTH'(16'h0001), 1'b0); drain();
        send(WIDTH'(16'h7FFF), WIDTH'(16'hFFFF), 1'b0); drain();
        send(WIDTH'(16'h0000), WIDTH'(16'h0000), 1'b1); drain();

        // backpressure: hold out_ready low, wiggle inputs, then release
        ready_mode = 2;
        bp_exp = model(WIDTH'(16'h1357), WIDTH'(16'h2468), 1'b1);
        send(WIDTH'(16'h1357), WIDTH'(16'h2468), 1'b1);
        wait_valid();
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_result", {diff, bout, ovf, zero}, bp_exp);
            in_valid = 1'($urandom_range(0, 1));
            a_in     = WIDTH'($urandom);
        end
        in_valid = 1'b0;
        #1 ready_mode = 1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_in_ready", in_ready, 1'b1);
        check("bp_release_out_valid", out_valid, 1'b0);
        check("bp_release_state", dbg_state, 2'd0);

        // reset on the second RUN edge (first, when there is only one)
        rst_edge = (N >= 2) ? 2 : 1;
        send(WIDTH'(16'hABCD), WIDTH'(16'h1111), 1'b0);
        repeat (rst_edge - 1) @(negedge clk);
        rst = 1'b1;
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_state", dbg_state, 2'd0);
        check("midrst_zero", zero, 1'b1);
        repeat (N + 3) begin
            @(negedge clk);
            check("midrst_no_valid", out_valid, 1'b0);
        end
        send(WIDTH'(16'h1234), WIDTH'(16'h0234), 1'b0); drain();

        // randomized regression with output stalls
        ready_mode = 0;
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 7))
                0:       ra = '0;
                1:       ra = '1;
                default: ra = WIDTH'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = '1;
                default: rb = WIDTH'($urandom);
            endcase
            send(ra, rb, 1'($urandom_range(0, 1)));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
